// File: rtl/fetch_queue_if.sv
// AXI read-address / read-data bundle between the fetch queue (master) and CRAM (slave).
interface fetch_queue_if #(
    parameter int unsigned DataW = 32,
    parameter int unsigned IdW   = 4
) ();
    logic [31:0]      araddr;
    logic             arvalid;
    logic             arready;
    logic [IdW-1:0]   arid;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arlock;
    logic [3:0]       arcache;
    logic [2:0]       arprot;
    logic [3:0]       arqos;
    logic             rvalid;
    logic [DataW-1:0] rdata;
    logic             rready;
    logic [IdW-1:0]   rid;
    logic [1:0]       rresp;
    logic             rlast;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
        output rready,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
        input  rready,
        output arready, rvalid, rdata, rid, rresp, rlast
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: keeps CRAM reads in flight, buffers returned words, predecodes
// jumps/branches to steer the fetch PC itself, and drains stale responses after a flush.
module fetch_queue #(
    parameter int unsigned AddrW  = 15,
    parameter int unsigned DataW  = 32,
    parameter int unsigned InstrW = 6,
    parameter int unsigned TgtW   = 15,
    parameter int unsigned QDepth = 4,
    parameter int unsigned MaxOut = 4,
    parameter int unsigned PcStep = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic             take_flag_i,
    input  logic             pred_miss_i,
    input  logic [AddrW-1:0] pred_miss_dst_i,
    fetch_queue_if.master    cram,
    input  logic             ready_i,
    output logic             current_valid_o,
    output logic [AddrW-1:0] current_pc_o,
    output logic [DataW-1:0] current_inst_o,
    output logic [AddrW-1:0] taken_pc_o,
    output logic [AddrW-1:0] untaken_pc_o
);
    localparam int unsigned PtrW  = $clog2(QDepth);
    localparam int unsigned TPtrW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
    localparam int unsigned CntW  = $clog2(QDepth + 1);

    localparam logic [InstrW-1:0] OpBle  = InstrW'(6'h10);
    localparam logic [InstrW-1:0] OpBlei = InstrW'(6'h11);
    localparam logic [InstrW-1:0] OpBlt  = InstrW'(6'h12);
    localparam logic [InstrW-1:0] OpBltf = InstrW'(6'h13);
    localparam logic [InstrW-1:0] OpBlti = InstrW'(6'h14);
    localparam logic [InstrW-1:0] OpBeq  = InstrW'(6'h15);
    localparam logic [InstrW-1:0] OpBeqf = InstrW'(6'h16);
    localparam logic [InstrW-1:0] OpBeqi = InstrW'(6'h17);
    localparam logic [InstrW-1:0] OpJmp  = InstrW'(6'h18);

    typedef struct packed {
        logic [AddrW-1:0] pc;
        logic [DataW-1:0] inst;
        logic             take;
    } entry_t;

    function automatic logic is_branch(input logic [InstrW-1:0] op);
        return op inside {OpBle, OpBlei, OpBlt, OpBltf, OpBlti, OpBeq, OpBeqf, OpBeqi};
    endfunction

    logic [AddrW-1:0] fetch_pc_q, fetch_pc_d, araddr_q, araddr_d;
    logic             arvalid_q, arvalid_d, stale_q, stale_d;
    logic [CntW-1:0]  out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TPtrW-1:0] twptr_q, twptr_d, trptr_q, trptr_d;
    entry_t           fifo_mem [QDepth];
    logic [AddrW-1:0] tag_mem  [MaxOut];

    logic             ar_hs, r_beat, r_keep, redirect, issue, pop, credit_ok;
    logic [InstrW-1:0] r_op;
    logic [AddrW-1:0] redir_tgt;
    entry_t           head, r_entry;

    assign cram.araddr  = 32'(araddr_q);
    assign cram.arvalid = arvalid_q;
    assign cram.arid    = '0;
    assign cram.arlen   = 8'd0;
    assign cram.arsize  = 3'd2;
    assign cram.arburst = 2'd1;
    assign cram.arlock  = 1'b0;
    assign cram.arcache = 4'd0;
    assign cram.arprot  = 3'd0;
    assign cram.arqos   = 4'd0;
    assign cram.rready  = 1'b1;

    // Beats arriving with nothing outstanding predate a reset and are ignored.
    assign ar_hs     = arvalid_q && cram.arready;
    assign r_beat    = cram.rvalid && (out_q != '0);
    assign r_keep    = r_beat && (drop_q == '0) && !pred_miss_i;
    assign r_op      = cram.rdata[DataW-1 -: InstrW];
    assign redirect  = r_keep && ((r_op == OpJmp) || (is_branch(r_op) && take_flag_i));
    assign redir_tgt = (r_op == OpJmp) ? AddrW'(cram.rdata[21:0]) : AddrW'(cram.rdata[TgtW-1:0]);
    assign credit_ok = (32'(out_q) + 32'(cnt_q) + 32'(drop_q) < QDepth) && (32'(out_q) < MaxOut);
    assign issue     = !arvalid_q && ce_i && !pred_miss_i && credit_ok;
    assign pop       = (cnt_q != '0) && ready_i && ce_i && !pred_miss_i;
    assign r_entry   = '{pc: tag_mem[trptr_q], inst: cram.rdata, take: take_flag_i};

    always_comb begin
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        stale_d    = stale_q;
        if (ar_hs) begin
            arvalid_d = 1'b0;
            out_d     = out_d + CntW'(1);
            stale_d   = 1'b0;
            if (stale_q) drop_d = drop_d + CntW'(1);
        end
        if (issue) begin
            arvalid_d  = 1'b1;
            araddr_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + AddrW'(PcStep);
        end
        if (r_beat) begin
            out_d = out_d - CntW'(1);
            if (drop_q != '0) drop_d = drop_d - CntW'(1);
        end
        // Everything already requested is on the wrong path, including a still-pending AR.
        if (pred_miss_i) begin
            fetch_pc_d = pred_miss_dst_i;
            drop_d     = out_d;
            stale_d    = arvalid_d;
        end else if (redirect) begin
            fetch_pc_d = redir_tgt;
            drop_d     = out_d;
            stale_d    = arvalid_d;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        twptr_d = twptr_q;
        trptr_d = trptr_q;
        if (r_keep) begin
            wptr_d = (wptr_q == PtrW'(QDepth - 1)) ? '0 : wptr_q + PtrW'(1);
            cnt_d  = cnt_d + CntW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(QDepth - 1)) ? '0 : rptr_q + PtrW'(1);
            cnt_d  = cnt_d - CntW'(1);
        end
        if (pred_miss_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
        if (ar_hs) twptr_d = (twptr_q == TPtrW'(MaxOut - 1)) ? '0 : twptr_q + TPtrW'(1);
        if (r_beat) trptr_d = (trptr_q == TPtrW'(MaxOut - 1)) ? '0 : trptr_q + TPtrW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= '0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            stale_q    <= 1'b0;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            twptr_q    <= '0;
            trptr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            stale_q    <= stale_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            twptr_q    <= twptr_d;
            trptr_q    <= trptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_keep) fifo_mem[wptr_q] <= r_entry;
        if (ar_hs) tag_mem[twptr_q] <= araddr_q;
    end

    assign head = fifo_mem[rptr_q];

    always_comb begin
        current_valid_o = (cnt_q != '0);
        current_pc_o    = '0;
        current_inst_o  = '0;
        taken_pc_o      = '0;
        untaken_pc_o    = '0;
        if (cnt_q != '0) begin
            current_pc_o   = head.pc;
            current_inst_o = head.inst;
            if (is_branch(head.inst[DataW-1 -: InstrW])) begin
                taken_pc_o   = head.take ? AddrW'(head.inst[TgtW-1:0])
                                         : head.pc + AddrW'(PcStep);
                untaken_pc_o = head.take ? head.pc + AddrW'(PcStep)
                                         : AddrW'(head.inst[TgtW-1:0]);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a CRAM responder returning words one cycle after AR,
// a head-pop monitor, and hand-computed expected PC sequences.
module tb_fetch_queue;
    localparam int unsigned AddrW = 15;
    localparam int unsigned DataW = 32;

    typedef logic [AddrW-1:0] pcq_t [$];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ce, take_flag, pred_miss, ready;
    logic [AddrW-1:0] dst;
    logic             cur_valid;
    logic [AddrW-1:0] cur_pc, taken_pc, untaken_pc;
    logic [DataW-1:0] cur_inst;

    logic             r_en;
    int               r_cnt;
    pcq_t             rq, ar_log, pop_pc, pop_tk, pop_un;
    logic [31:0]      prog [int];
    logic             tk [int];
    int               checks = 0;
    int               errors = 0;

    fetch_queue_if #(.DataW(DataW)) bus ();

    fetch_queue #(
        .AddrW(AddrW), .DataW(DataW), .InstrW(6), .TgtW(15),
        .QDepth(4), .MaxOut(4), .PcStep(4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ce_i            (ce),
        .take_flag_i     (take_flag),
        .pred_miss_i     (pred_miss),
        .pred_miss_dst_i (dst),
        .cram            (bus),
        .ready_i         (ready),
        .current_valid_o (cur_valid),
        .current_pc_o    (cur_pc),
        .current_inst_o  (cur_inst),
        .taken_pc_o      (taken_pc),
        .untaken_pc_o    (untaken_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input pcq_t q, input int i);
        return (i < q.size()) ? 32'(q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rq.delete();
        ar_log.delete();
        pop_pc.delete();
        pop_tk.delete();
        pop_un.delete();
        r_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pred_miss = 1'b0;
        repeat (2) @(posedge clk);
        clear_logs();
        #2;
        rst_n = 1'b1;
    endtask

    // CRAM responder: each accepted AR is answered by one beat, earliest the next cycle.
    initial begin
        logic [AddrW-1:0] a;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        bus.rid    = '0;
        bus.rresp  = '0;
        bus.rlast  = 1'b1;
        take_flag  = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_n && bus.arvalid && bus.arready) begin
                rq.push_back(bus.araddr[AddrW-1:0]);
                ar_log.push_back(bus.araddr[AddrW-1:0]);
            end
            #1;
            bus.rvalid = 1'b0;
            bus.rdata  = '0;
            take_flag  = 1'b0;
            if (r_en && rq.size() != 0) begin
                a          = rq.pop_front();
                bus.rvalid = 1'b1;
                bus.rdata  = prog.exists(int'(a)) ? prog[int'(a)] : 32'h0;
                take_flag  = tk.exists(int'(a)) ? tk[int'(a)] : 1'b0;
                r_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cur_valid && ready && ce && !pred_miss) begin
                pop_pc.push_back(cur_pc);
                pop_tk.push_back(taken_pc);
                pop_un.push_back(untaken_pc);
            end
        end
    end

    initial begin
        ce = 1'b1; ready = 1'b1; pred_miss = 1'b0; dst = '0; r_en = 1'b1; r_cnt = 0;
        bus.arready = 1'b1;

        // 1: straight-line NOP stream
        do_reset();
        check_eq("rst_valid", 32'(cur_valid), 0);
        check_eq("rst_arvalid", 32'(bus.arvalid), 0);
        check_eq("rst_araddr", bus.araddr, 0);
        check_eq("rst_taken", 32'(taken_pc), 0);
        cyc(1);
        check_eq("t1_ar0_valid", 32'(bus.arvalid), 1);
        check_eq("t1_ar0_addr", bus.araddr, 0);
        cyc(1);
        check_eq("t1_head_not_yet", 32'(cur_valid), 0);
        cyc(1);
        check_eq("t1_head_valid", 32'(cur_valid), 1);
        check_eq("t1_head_pc", 32'(cur_pc), 0);
        check_eq("t1_ar1_addr", bus.araddr, 4);
        cyc(20);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t1_ar[%0d]", i), qat(ar_log, i), 32'(4 * i));
            check_eq($sformatf("t1_pop[%0d]", i), qat(pop_pc, i), 32'(4 * i));
        end

        // 2: back-pressure fills the queue, ce=0 holds it, then drain in order
        ready = 1'b0;
        do_reset();
        cyc(12);
        check_eq("t2_ar_count", ar_log.size(), 4);
        check_eq("t2_beats", 32'(r_cnt), 4);
        check_eq("t2_arvalid_off", 32'(bus.arvalid), 0);
        check_eq("t2_head_pc", 32'(cur_pc), 0);
        ce = 1'b0; ready = 1'b1;
        cyc(3);
        check_eq("t2_ce0_nopop", pop_pc.size(), 0);
        check_eq("t2_ce0_noar", ar_log.size(), 4);
        ce = 1'b1;
        cyc(25);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("t2_pop[%0d]", i), qat(pop_pc, i), 32'(4 * i));

        // 3: taken BEQ at pc 8 with two reads behind it
        prog[8] = 32'h5400_0040;
        tk[8]   = 1'b1;
        r_en    = 1'b0;
        do_reset();
        cyc(9);
        r_en = 1'b1;
        cyc(30);
        check_eq("t3_pop0", qat(pop_pc, 0), 32'h0);
        check_eq("t3_pop1", qat(pop_pc, 1), 32'h4);
        check_eq("t3_pop2", qat(pop_pc, 2), 32'h8);
        check_eq("t3_pop3", qat(pop_pc, 3), 32'h40);
        check_eq("t3_pop4", qat(pop_pc, 4), 32'h44);
        check_eq("t3_taken", qat(pop_tk, 2), 32'h40);
        check_eq("t3_untaken", qat(pop_un, 2), 32'hC);
        check_eq("t3_nop_taken", qat(pop_tk, 0), 32'h0);
        check_eq("t3_stale_ar", qat(ar_log, 4), 32'h10);
        check_eq("t3_redir_ar", qat(ar_log, 5), 32'h40);
        prog.delete();
        tk.delete();

        // 4: pred_miss with three reads outstanding and one AR stalled
        r_en = 1'b0;
        do_reset();
        cyc(6);
        bus.arready = 1'b0;
        cyc(3);
        check_eq("t4_pend_valid", 32'(bus.arvalid), 1);
        check_eq("t4_pend_addr", bus.araddr, 12);
        pred_miss = 1'b1;
        dst       = 15'h100;
        cyc(1);
        pred_miss = 1'b0;
        check_eq("t4_hold_valid", 32'(bus.arvalid), 1);
        check_eq("t4_hold_addr", bus.araddr, 12);
        check_eq("t4_empty", 32'(cur_valid), 0);
        cyc(1);
        bus.arready = 1'b1;
        cyc(1);
        r_en = 1'b1;
        cyc(25);
        check_eq("t4_ar3", qat(ar_log, 3), 32'hC);
        check_eq("t4_ar4", qat(ar_log, 4), 32'h100);
        check_eq("t4_pop0", qat(pop_pc, 0), 32'h100);
        check_eq("t4_pop1", qat(pop_pc, 1), 32'h104);

        // 5: unconditional jump at pc 4
        prog[4] = 32'h6000_0200;
        do_reset();
        cyc(25);
        check_eq("t5_pop0", qat(pop_pc, 0), 32'h0);
        check_eq("t5_pop1", qat(pop_pc, 1), 32'h4);
        check_eq("t5_pop2", qat(pop_pc, 2), 32'h200);
        check_eq("t5_pop3", qat(pop_pc, 3), 32'h204);
        check_eq("t5_jmp_taken", qat(pop_tk, 1), 32'h0);
        check_eq("t5_jmp_untaken", qat(pop_un, 1), 32'h0);
        check_eq("t5_ar2", qat(ar_log, 2), 32'h8);
        check_eq("t5_ar3", qat(ar_log, 3), 32'h200);
        prog.delete();

        // 6: reset mid-burst with two reads outstanding
        ready = 1'b0;
        do_reset();
        cyc(3);
        r_en = 1'b0;
        cyc(4);
        check_eq("t6_pre_valid", 32'(cur_valid), 1);
        check_eq("t6_pre_arvalid", 32'(bus.arvalid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(cur_valid), 0);
        check_eq("t6_rst_pc", 32'(cur_pc), 0);
        check_eq("t6_rst_inst", cur_inst, 0);
        check_eq("t6_rst_arvalid", 32'(bus.arvalid), 0);
        check_eq("t6_rst_araddr", bus.araddr, 0);
        r_en = 1'b1;
        cyc(4);
        clear_logs();
        ready = 1'b1;
        rst_n = 1'b1;
        cyc(20);
        check_eq("t6_ar0", qat(ar_log, 0), 32'h0);
        check_eq("t6_pop0", qat(pop_pc, 0), 32'h0);
        check_eq("t6_pop1", qat(pop_pc, 1), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
